// File: rtl/adc_fp_feeder.sv
// -----------------------------------------------------------------------------
// adc_fp_feeder
//
// Purpose:
//   Upstream stage of calibration_top. A go pulse in IDLE opens a burst of
//   BURST_LEN signed ADC samples. Each accepted sample is converted to an
//   IEEE-754 single-precision value by a fixed 3-stage pipeline and presented
//   on o_data/o_valid. A one-cycle o_done follows the last result of a burst
//   by exactly one cycle.
//
// Ports:
//   i_clk         system clock, all logic on the rising edge
//   i_rst         synchronous reset, active-high; aborts any burst in flight
//   i_go          start pulse, honoured only in IDLE
//   i_adc_data    ADC sample code (two's complement, or offset binary when
//                 ADC_OFFSET_BIN_EN is defined)
//   i_adc_valid   sample qualifier, one sample per high cycle (CAPTURE only)
//   o_busy        high in every state except IDLE
//   o_data        IEEE-754 single result, holds its value while o_valid=0
//   o_valid       o_data qualifier, one cycle per result
//   o_done        one-cycle pulse one cycle after the last result of a burst
//   o_dbg_state   current FSM state (IDLE=0, CAPTURE=1, FLUSH=2, DONE=3)
//
// Handshake:
//   There is no backpressure in either direction. An input sample is taken
//   on every rising edge where i_adc_valid=1 and the FSM is in CAPTURE; the
//   matching result appears with o_valid=1 exactly three cycles later, and
//   the consumer must take it in that cycle.
//
// Configuration:
//   ADC_OFFSET_BIN_EN  when defined, i_adc_data is offset binary and its MSB
//                      is inverted before the sign/magnitude split.
//
// Parameters:
//   ADC_W      ADC code width, 2..24 (every code converts exactly)
//   BURST_LEN  samples accepted per go, >= 1
//   CNT_W      sample counter width, 2**CNT_W > BURST_LEN
// -----------------------------------------------------------------------------
module adc_fp_feeder #(
  parameter int ADC_W     = 12,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic [ADC_W-1:0] i_adc_data,
  input  logic             i_adc_valid,
  output logic             o_busy,
  output logic [31:0]      o_data,
  output logic             o_valid,
  output logic             o_done,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // Pipeline registers
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [ADC_W-1:0] r_s1_mag;

  logic             r_s2_valid;
  logic             r_s2_sign;
  logic             r_s2_zero;
  logic [4:0]       r_s2_pos;
  logic [ADC_W-1:0] r_s2_mag;

  logic             r_s3_valid;
  logic [31:0]      r_s3_data;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             w_accept;
  logic             w_last;
  logic             w_drain;
  logic [ADC_W-1:0] w_code;
  logic             w_sign;
  logic [ADC_W-1:0] w_mag;
  logic [4:0]       w_pos;
  logic [7:0]       w_exp;
  logic [23:0]      w_ext;
  logic [23:0]      w_shift;
  logic [22:0]      w_mant;

  assign w_accept = (r_state == ST_CAPTURE) && i_adc_valid;
  assign w_last   = (r_cnt == CNT_W'(BURST_LEN - 1));

  // Once stages 1 and 2 are empty in FLUSH, stage 3 holds at most the final
  // result, which leaves the pipeline on the same edge that enters DONE.
  // That places o_done exactly one cycle after the last o_valid, and all
  // three valid bits are clear during the DONE cycle.
  assign w_drain  = !r_s1_valid && !r_s2_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // i_adc_valid is ignored here, including in the go cycle itself.
          if (i_go) begin
            r_state <= ST_CAPTURE;
            r_cnt   <= '0;
          end
        end
        ST_CAPTURE: begin
          // A go seen here is deliberately ignored; the count carries on.
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_drain) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: sign / magnitude
  // ---------------------------------------------------------------------------
`ifdef ADC_OFFSET_BIN_EN
  // Offset binary becomes two's complement by flipping the MSB.
  assign w_code = {~i_adc_data[ADC_W-1], i_adc_data[ADC_W-2:0]};
`else
  assign w_code = i_adc_data;
`endif

  assign w_sign = w_code[ADC_W-1];
  // The most negative code negates to 2**(ADC_W-1), which still fits when
  // the magnitude is read as unsigned.
  assign w_mag  = w_sign ? (~w_code + ADC_W'(1)) : w_code;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sign <= w_sign;
        r_s1_mag  <= w_mag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: leading-one position
  // ---------------------------------------------------------------------------
  // Ascending scan, so the highest set bit wins.
  always_comb begin
    w_pos = 5'd0;
    for (int i = 0; i < ADC_W; i++) begin
      if (r_s1_mag[i]) begin
        w_pos = 5'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_pos   <= '0;
      r_s2_mag   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign <= r_s1_sign;
        r_s2_zero <= (r_s1_mag == '0);
        r_s2_pos  <= w_pos;
        r_s2_mag  <= r_s1_mag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: exponent, mantissa, assembly
  // ---------------------------------------------------------------------------
  assign w_exp   = 8'd127 + {3'b000, r_s2_pos};
  // Shifting the leading one up to bit 23 leaves the bits below it
  // left-aligned in [22:0]; the implicit one drops off the top.
  assign w_ext   = 24'(r_s2_mag);
  assign w_shift = w_ext << (5'd23 - r_s2_pos);
  assign w_mant  = w_shift[22:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s3_valid <= 1'b0;
      r_s3_data  <= 32'h0000_0000;
    end else begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        // Zero always comes out as +0.0, never -0.0.
        if (r_s2_zero) begin
          r_s3_data <= 32'h0000_0000;
        end else begin
          r_s3_data <= {r_s2_sign, w_exp, w_mant};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_data      = r_s3_data;
  assign o_valid     = r_s3_valid;
  assign o_done      = r_done;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc_fp_feeder.sv
// -----------------------------------------------------------------------------
// tb_adc_fp_feeder: self-checking bench for adc_fp_feeder.
// Expected results are pushed when a sample is driven into an accepting DUT
// and popped when o_valid appears; o_done is checked against its own queue.
// -----------------------------------------------------------------------------
module tb_adc_fp_feeder;

  localparam int ADC_W     = 12;
  localparam int BURST_LEN = 16;
  localparam int CNT_W     = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        busy;
  logic [31:0] data;
  logic        valid;
  logic        done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adc_fp_feeder #(
    .ADC_W    (ADC_W),
    .BURST_LEN(BURST_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_go       (go),
    .i_adc_data (adc_data),
    .i_adc_valid(adc_valid),
    .o_busy     (busy),
    .o_data     (data),
    .o_valid    (valid),
    .o_done     (done),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];
  int          exp_t_q[$];
  int          done_q[$];

  logic        m_capture  = 1'b0;
  int          m_count    = 0;
  int          m_idle_edge = 0;
  logic [31:0] m_last     = 32'h0;
  logic        m_last_ok  = 1'b0;
  logic        mon_en     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference conversion: normalise by shifting until bit 23 is set.
  function automatic logic [31:0] ref_fp(input logic [11:0] code);
    logic [11:0] c;
    int          v;
    int          m;
    int          e;
    logic        s;
    logic [23:0] mm;
    c = code;
`ifdef ADC_OFFSET_BIN_EN
    c[11] = ~c[11];
`endif
    v = int'($signed(c));
    if (v == 0) return 32'h0;
    s  = (v < 0);
    m  = s ? -v : v;
    mm = m[23:0];
    e  = 150;
    while (!mm[23]) begin
      mm = mm << 1;
      e--;
    end
    return {s, e[7:0], mm[22:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [31:0] e;
    int          t;
    if (mon_en) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'(valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check_eq("data", data, e);
          check_eq("latency", 32'(cyc), 32'(t));
          m_last = e;
        end
      end else if (m_last_ok) begin
        check_eq("hold", data, m_last);
      end
      if (done) begin
        if (done_q.size() == 0) check_eq("unexpected_done", 32'(done), 32'h0);
        else check_eq("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1; go = 1'b0; adc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); exp_t_q.delete(); done_q.delete();
    m_capture = 1'b0; m_count = 0; m_idle_edge = 0;
    m_last = 32'h0; m_last_ok = 1'b1;
    check_eq("rst_data",  data, 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_done",  32'(done), 32'h0);
    check_eq("rst_busy",  32'(busy), 32'h0);
  endtask

  // One clock with the given inputs; expv is the result if the sample is taken.
  task automatic step(input logic g, input logic v, input logic [11:0] d,
                      input logic [31:0] expv);
    int   pre;
    logic idle_pre;
    logic exp_busy;
    go = g; adc_valid = v; adc_data = d;
    pre      = cyc;
    idle_pre = !m_capture && (pre >= m_idle_edge);
    @(posedge clk); #1;
    if (m_capture && v) begin
      exp_q.push_back(expv);
      exp_t_q.push_back(pre + 3);
      m_count++;
      if (m_count == BURST_LEN) begin
        m_capture   = 1'b0;
        m_idle_edge = pre + 5;
        done_q.push_back(pre + 4);
      end
    end else if (idle_pre && g) begin
      m_capture = 1'b1;
      m_count   = 0;
    end
    exp_busy = m_capture || (cyc < m_idle_edge);
    check_eq("busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic rnd_sample(input logic g, input logic v);
    logic [11:0] d;
    d = 12'($urandom_range(0, 4095));
    step(g, v, d, ref_fp(d));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && done_q.size() == 0 && !m_capture &&
          cyc >= m_idle_edge) break;
      step(1'b0, 1'b0, 12'h0, 32'h0);
    end
    check_eq("drain", 32'(exp_q.size() + done_q.size()), 32'h0);
    check_eq("idle_busy", 32'(busy), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; go = 1'b0; adc_valid = 1'b0; adc_data = 12'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Directed conversions, then the rest of the burst, then a 17th sample.
    step(1'b1, 1'b1, 12'h123, 32'h0);   // go cycle: sample not taken
`ifdef ADC_OFFSET_BIN_EN
    step(1'b0, 1'b1, 12'h800, 32'h00000000);
    step(1'b0, 1'b1, 12'h802, 32'h40000000);
    step(1'b0, 1'b1, 12'h000, 32'hC5000000);
    step(1'b0, 1'b1, 12'h801, 32'h3F800000);
    step(1'b0, 1'b1, 12'hFFF, 32'h44FFE000);
    step(1'b0, 1'b1, 12'h7FF, 32'hBF800000);
`else
    step(1'b0, 1'b1, 12'h001, 32'h3F800000);
    step(1'b0, 1'b1, 12'h002, 32'h40000000);
    step(1'b0, 1'b1, 12'h000, 32'h00000000);
    step(1'b0, 1'b1, 12'hFFF, 32'hBF800000);
    step(1'b0, 1'b1, 12'h800, 32'hC5000000);
    step(1'b0, 1'b1, 12'h7FF, 32'h44FFE000);
`endif
    for (int i = 6; i < BURST_LEN; i++) rnd_sample(1'b0, 1'b1);
    rnd_sample(1'b0, 1'b1);             // 17th: FSM already in FLUSH
    wait_idle(40);

    // Back-to-back full burst with extra samples after the end.
    step(1'b1, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < BURST_LEN + 3; i++) rnd_sample(1'b0, 1'b1);
    wait_idle(40);

    // Samples in IDLE are dropped; a go during CAPTURE does not restart.
    for (int i = 0; i < 4; i++) rnd_sample(1'b0, 1'b1);
    step(1'b1, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < 5; i++) rnd_sample(1'b0, 1'b1);
    rnd_sample(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) rnd_sample(1'b0, 1'($urandom_range(0, 1)));
    wait_idle(60);

    // Reset with two samples in the pipeline: they must vanish.
    step(1'b1, 1'b0, 12'h0, 32'h0);
    rnd_sample(1'b0, 1'b1);
    rnd_sample(1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 12'h0, 32'h0);

    // Recovery burst with random gaps.
    step(1'b1, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < 60; i++) rnd_sample(1'b0, 1'($urandom_range(0, 1)));
    wait_idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_fp_feeder.md
Name: adc_fp_feeder

Overview:
- Upstream stage of calibration_top.
- On a `go` pulse, captures a burst of BURST_LEN signed ADC samples and converts each to IEEE-754 single precision in a 3-stage pipeline.
- Presents each result as `data`/`valid`, the exact stream calibration_top consumes for its floating-point accumulate.
- Signals end of burst with a one-cycle `done`.

Parameters:
- ADC_W, 12, ADC code width; legal range 2..24, so every conversion is exact with no rounding.
- BURST_LEN, 16, samples accepted per `go`; minimum 1.
- CNT_W, 5, sample counter width; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- go  in  1  start pulse; honoured only in IDLE.
- adc_data  in  ADC_W  sample code, two's complement by default.
- adc_valid  in  1  adc_data qualifier, one sample per high cycle.
- busy  out  1  high in every state except IDLE.
- data  out  32  IEEE-754 single result, fed to calibration_top.data.
- valid  out  1  data qualifier, fed to calibration_top.valid.
- done  out  1  one-cycle pulse after the last result of a burst.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; counter=0; all pipeline valid bits clear.
  - Outputs: data=32'h0, valid=0, done=0, busy=0.
  - rst during CAPTURE or FLUSH aborts the burst. In-flight samples are dropped: no valid and no done for them.
- FSM states: IDLE, CAPTURE, FLUSH, DONE.
  - IDLE: go=1 -> CAPTURE, counter=0. adc_valid is ignored.
  - CAPTURE: each cycle with adc_valid=1 injects the sample into pipeline stage 1 and increments the counter. When the accepted sample is number BURST_LEN -> FLUSH. adc_valid in the same cycle as the go that starts the burst is not accepted; capture begins the next cycle.
  - FLUSH: no new samples accepted. -> DONE once all three pipeline valid bits are 0.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - go outside IDLE is ignored. go in the DONE cycle is ignored; a new burst needs go in IDLE.
- Pipeline, fixed latency 3: valid is asserted 3 cycles after the cycle adc_valid was accepted. No stalls; one result per accepted sample.
  - S1: register sign = adc_data[ADC_W-1] and mag = |adc_data|, ADC_W bits unsigned. The code -2^(ADC_W-1) yields mag = 2^(ADC_W-1), which fits unsigned.
  - S2: priority-encode the leading-one position p of mag; register p, mag, sign, and zero flag = (mag==0).
  - S3: exp = 127 + p; mantissa = mag bits below p, left-aligned into 23 bits, zero-filled.
  - Output assembly: data = {sign, exp[7:0], mantissa}. If zero: data = 32'h00000000 with sign cleared, so there is never a -0.
- data holds its last value while valid=0.
- busy = (state != IDLE), decoded from registered state.
- The last valid of a burst precedes done by exactly 1 cycle.

Optional Feature:
- Macro: ADC_OFFSET_BIN_EN.
- Defined: adc_data is offset binary. Stage 1 inverts the MSB before sign/magnitude, so code 12'h800 maps to 0.0 and 12'h000 maps to -2048.0. Latency is unchanged.
- Undefined: adc_data is two's complement as specified above; no extra logic.

Test Plan:
- Reset, go, then samples 12'h001, 12'h002, 12'h000 -> data 3F800000, 40000000, 00000000 on valid, each 3 cycles after its sample.
- Samples 12'hFFF, 12'h800, 12'h7FF -> data BF800000, C5000000, 44FFE000.
- Full burst of 16 back-to-back samples -> 16 valids, then done exactly 1 cycle after the last valid. A 17th adc_valid is ignored. busy drops with the return to IDLE.
- adc_valid in IDLE; go pulsed again during CAPTURE -> no valid output for the IDLE samples; the counter is not reset by the second go.
- rst asserted mid-burst with 2 samples in the pipeline -> no further valid or done; all outputs at reset values the next cycle.
- ADC_OFFSET_BIN_EN defined: 12'h800 -> 00000000; 12'h802 -> 40000000; 12'h000 -> C5000000.
